// File: rtl/iir_inverse.sv
// Inverse of a first-order Q16.16 IIR stage: recovers the forward filter's input
// sample from its output, one sample at a time, using a single shared multiplier.
module iir_inverse #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] y_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [N_BITS-1:0] b1_i,
    input  logic [N_BITS-1:0] inv_b0_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] offset_i,
    input  logic              clear_i,
    output logic [N_BITS-1:0] x_o,
    output logic              valid_o,
    input  logic              ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_B1,
        MUL_INV,
        MUL_A,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic [N_BITS-1:0] y_r, b1_r, inv_b0_r, a_r, off_r;
    logic [N_BITS-1:0] w1, w0, p;

    logic signed [N_BITS-1:0]   mul_x, mul_y;
    logic signed [2*N_BITS-1:0] prod;
    logic [N_BITS-1:0]          mres;
    logic                       prod_unused;

    // Shared multiplier operands selected by the current state
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            MUL_B1: begin
                mul_x = b1_r;
                mul_y = w1;
            end
            MUL_INV: begin
                mul_x = inv_b0_r;
                mul_y = y_r - p;
            end
            MUL_A: begin
                mul_x = a_r;
                mul_y = w1;
            end
            default: ;
        endcase
    end

    assign prod        = (2*N_BITS)'(mul_x) * (2*N_BITS)'(mul_y);
    assign mres        = prod[N_BITS+15:16];
    assign prod_unused = ^{prod[2*N_BITS-1:N_BITS+16], prod[15:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i)
                    state_nxt = MUL_B1;
            end
            MUL_B1:  state_nxt = MUL_INV;
            MUL_INV: state_nxt = MUL_A;
            MUL_A:   state_nxt = OUT;
            OUT: begin
                valid_o = 1'b1;
                if (ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_r      <= '0;
            b1_r     <= '0;
            inv_b0_r <= '0;
            a_r      <= '0;
            off_r    <= '0;
            w1       <= '0;
            w0       <= '0;
            p        <= '0;
            x_o      <= '0;
        end else if (clear_i) begin
            w1  <= '0;
            w0  <= '0;
            p   <= '0;
            x_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        y_r      <= y_i;
                        b1_r     <= b1_i;
                        inv_b0_r <= inv_b0_i;
                        a_r      <= a_i;
                        off_r    <= offset_i;
                    end
                end
                MUL_B1:  p   <= mres;
                MUL_INV: w0  <= mres;
                MUL_A:   x_o <= w0 + mres - off_r;
                OUT: begin
                    if (ready_i)
                        w1 <= w0;
                end
                default: ;
            endcase
        end
    end

endmodule
